// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//
// Generates the instruction fetch address stream. The PC advances by 4 on
// every accepted fetch, and a branch redirect replaces it with the branch
// target. Each redirect bumps a 2-bit epoch tag so that downstream stages can
// discard instructions from the old path. If a redirect arrives while the
// fetch stage is stalled, the target is parked in a pending register (HOLD).
// It is applied on the next accepted fetch. The block also owns the link (LR)
// and count (CTR) registers. These are written by branch results or by mtspr,
// and a branch write takes priority over an mtspr write.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   br_valid/br_ready     branch result handshake
//   nia_valid, nia_in     redirect request and target
//   link_reg_valid/_in    branch write of LR
//   count_reg_valid/_in   branch write of CTR
//   spr_valid/spr_ready   mtspr handshake; spr_sel 0 = LR, 1 = CTR
//   spr_data              mtspr write data
//   link_reg_out          current LR
//   count_reg_out         current CTR
//   fetch_valid/_ready    fetch address handshake
//   fetch_addr            word-aligned fetch address
//   fetch_epoch           redirect generation of fetch_addr
// ---------------------------------------------------------------------------
module fetch_sequencer #(
  parameter logic [0:31] RESET_ADDR = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        br_valid,
  output logic        br_ready,
  input  logic        nia_valid,
  input  logic [0:31] nia_in,
  input  logic        link_reg_valid,
  input  logic [0:31] link_reg_in,
  input  logic        count_reg_valid,
  input  logic [0:31] count_reg_in,
  input  logic        spr_valid,
  output logic        spr_ready,
  input  logic        spr_sel,
  input  logic [0:31] spr_data,
  output logic [0:31] link_reg_out,
  output logic [0:31] count_reg_out,
  output logic        fetch_valid,
  input  logic        fetch_ready,
  output logic [0:31] fetch_addr,
  output logic [0:1]  fetch_epoch
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [0:31] pc_q, pc_d;
  logic [0:31] pend_q, pend_d;
  logic [0:1]  epoch_q, epoch_d;
  logic [0:31] lr_q, lr_d;
  logic [0:31] ctr_q, ctr_d;

  logic        fetch_hs_s;
  logic        br_hs_s;
  logic        redirect_s;
  logic        spr_hs_s;
  logic        spr_conflict_s;
  logic [0:31] target_s;

  // Handshake qualifiers and ready outputs; everything is gated off in reset.
  always_comb begin
    fetch_valid    = ~rst;
    br_ready       = ~rst & (state_q == ST_RUN);
    fetch_hs_s     = fetch_valid & fetch_ready;
    br_hs_s        = br_valid & br_ready;
    redirect_s     = br_hs_s & nia_valid;
    // Low two bits are forced to zero so the target is always word aligned.
    target_s       = nia_in & 32'hFFFF_FFFC;
    // mtspr stalls only when the branch writes the same register this cycle.
    spr_conflict_s = br_hs_s & (spr_sel ? count_reg_valid : link_reg_valid);
    spr_ready      = ~rst & ~spr_conflict_s;
    spr_hs_s       = spr_valid & spr_ready;
  end

  // Next-state logic for the PC, epoch and redirect buffer.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    epoch_d = epoch_q;
    case (state_q)
      ST_RUN: begin
        if (redirect_s & fetch_ready) begin
          // The current address is consumed and the redirect takes effect at once.
          pc_d    = target_s;
          epoch_d = epoch_q + 2'd1;
        end else if (redirect_s) begin
          // Fetch is stalled, so fetch_addr must not move. Park the target.
          pend_d  = target_s;
          state_d = ST_HOLD;
        end else if (fetch_hs_s) begin
          pc_d = pc_q + 32'd4;
        end else begin
          pc_d = pc_q;
        end
      end
      ST_HOLD: begin
        if (fetch_hs_s) begin
          pc_d    = pend_q;
          pend_d  = 32'd0;
          epoch_d = epoch_q + 2'd1;
          state_d = ST_RUN;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Next-state logic for LR and CTR; a branch write beats an mtspr write.
  always_comb begin
    lr_d  = lr_q;
    ctr_d = ctr_q;
    if (br_hs_s & link_reg_valid) begin
      lr_d = link_reg_in;
    end else if (spr_hs_s & ~spr_sel) begin
      lr_d = spr_data;
    end else begin
      lr_d = lr_q;
    end
    if (br_hs_s & count_reg_valid) begin
      ctr_d = count_reg_in;
    end else if (spr_hs_s & spr_sel) begin
      ctr_d = spr_data;
    end else begin
      ctr_d = ctr_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_ADDR;
      pend_q  <= 32'd0;
      epoch_q <= 2'd0;
      lr_q    <= 32'd0;
      ctr_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      epoch_q <= epoch_d;
      lr_q    <= lr_d;
      ctr_q   <= ctr_d;
    end
  end

  assign fetch_addr    = pc_q;
  assign fetch_epoch   = epoch_q;
  assign link_reg_out  = lr_q;
  assign count_reg_out = ctr_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Directed stimulus with a reference model of the fetch sequencer.
// The model keeps the PC, epoch, LR and CTR, plus a queue of buffered
// redirects. A compare process checks every DUT output against the model at
// each falling edge. Hand-computed literal checks pin the model itself.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

  localparam logic [31:0] RST_A = 32'h0000_0100;

  logic        clk;
  logic        rst;
  logic        br_valid;
  logic        br_ready;
  logic        nia_valid;
  logic [0:31] nia_in;
  logic        link_reg_valid;
  logic [0:31] link_reg_in;
  logic        count_reg_valid;
  logic [0:31] count_reg_in;
  logic        spr_valid;
  logic        spr_ready;
  logic        spr_sel;
  logic [0:31] spr_data;
  logic [0:31] link_reg_out;
  logic [0:31] count_reg_out;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [0:31] fetch_addr;
  logic [0:1]  fetch_epoch;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_lr;
  logic [31:0] m_ctr;
  logic [1:0]  m_ep;
  logic [31:0] m_pend[$];
  bit          m_known = 1'b0;

  fetch_sequencer #(.RESET_ADDR(RST_A)) dut (
    .clk             (clk),
    .rst             (rst),
    .br_valid        (br_valid),
    .br_ready        (br_ready),
    .nia_valid       (nia_valid),
    .nia_in          (nia_in),
    .link_reg_valid  (link_reg_valid),
    .link_reg_in     (link_reg_in),
    .count_reg_valid (count_reg_valid),
    .count_reg_in    (count_reg_in),
    .spr_valid       (spr_valid),
    .spr_ready       (spr_ready),
    .spr_sel         (spr_sel),
    .spr_data        (spr_data),
    .link_reg_out    (link_reg_out),
    .count_reg_out   (count_reg_out),
    .fetch_valid     (fetch_valid),
    .fetch_ready     (fetch_ready),
    .fetch_addr      (fetch_addr),
    .fetch_epoch     (fetch_epoch)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Advance the model by one rising edge, using the inputs seen at that edge.
  task automatic model_step();
    bit          brdy, bhs, sel_w, srdy;
    logic [31:0] tgt;
    if (rst) begin
      m_pc    = RST_A;
      m_ep    = 2'd0;
      m_lr    = 32'd0;
      m_ctr   = 32'd0;
      m_pend.delete();
      m_known = 1'b1;
    end else begin
      brdy  = (m_pend.size() == 0);
      bhs   = br_valid && brdy;
      sel_w = spr_sel ? count_reg_valid : link_reg_valid;
      srdy  = !(bhs && sel_w);
      tgt   = nia_in & 32'hFFFF_FFFC;
      if (!brdy) begin
        if (fetch_ready) begin
          m_pc = m_pend.pop_front();
          m_ep = m_ep + 2'd1;
        end
      end else if (bhs && nia_valid) begin
        if (fetch_ready) begin
          m_pc = tgt;
          m_ep = m_ep + 2'd1;
        end else begin
          m_pend.push_back(tgt);
        end
      end else if (fetch_ready) begin
        m_pc = m_pc + 32'd4;
      end
      if (bhs && link_reg_valid)            m_lr  = link_reg_in;
      else if (spr_valid && srdy && !spr_sel) m_lr  = spr_data;
      if (bhs && count_reg_valid)           m_ctr = count_reg_in;
      else if (spr_valid && srdy && spr_sel)  m_ctr = spr_data;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare all DUT outputs against the model at every falling edge.
  initial forever begin
    bit e_brdy, e_bhs, e_sel, e_srdy;
    @(negedge clk);
    e_brdy = !rst && (m_pend.size() == 0);
    e_bhs  = br_valid && e_brdy;
    e_sel  = spr_sel ? count_reg_valid : link_reg_valid;
    e_srdy = !rst && !(e_bhs && e_sel);
    chk("m_fetch_valid", {31'd0, fetch_valid}, {31'd0, !rst});
    chk("m_br_ready",    {31'd0, br_ready},    {31'd0, e_brdy});
    chk("m_spr_ready",   {31'd0, spr_ready},   {31'd0, e_srdy});
    if (m_known) begin
      chk("m_fetch_addr",  fetch_addr,             m_pc);
      chk("m_fetch_epoch", {30'd0, fetch_epoch},   {30'd0, m_ep});
      chk("m_lr",          link_reg_out,           m_lr);
      chk("m_ctr",         count_reg_out,          m_ctr);
    end
  end

  initial begin
    rst = 1'b1; br_valid = 1'b0; nia_valid = 1'b0; nia_in = 32'd0;
    link_reg_valid = 1'b0; link_reg_in = 32'd0;
    count_reg_valid = 1'b0; count_reg_in = 32'd0;
    spr_valid = 1'b0; spr_sel = 1'b0; spr_data = 32'd0; fetch_ready = 1'b0;

    // Reset: valid and ready outputs are held low
    cyc(2);
    chk("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
    chk("rst_br_ready",    {31'd0, br_ready},    32'd0);
    chk("rst_spr_ready",   {31'd0, spr_ready},   32'd0);

    // Release: sequential fetch 0x100, 0x104, 0x108
    rst = 1'b0; fetch_ready = 1'b1; #1;
    chk("rel_valid", {31'd0, fetch_valid}, 32'd1);
    chk("rel_addr",  fetch_addr, 32'h0000_0100);
    chk("rel_epoch", {30'd0, fetch_epoch}, 32'd0);
    cyc(1); chk("seq_104", fetch_addr, 32'h0000_0104);
    cyc(1); chk("seq_108", fetch_addr, 32'h0000_0108);
    cyc(62); chk("seq_200", fetch_addr, 32'h0000_0200);

    // Redirect with fetch_ready high: misaligned target is truncated
    br_valid = 1'b1; nia_valid = 1'b1; nia_in = 32'h0000_1003; #1;
    chk("redir_br_ready", {31'd0, br_ready}, 32'd1);
    cyc(1); br_valid = 1'b0; nia_valid = 1'b0; #1;
    chk("redir_addr",  fetch_addr, 32'h0000_1000);
    chk("redir_epoch", {30'd0, fetch_epoch}, 32'd1);

    // Redirect during a stall: HOLD, address held stable, later branch refused
    fetch_ready = 1'b0; br_valid = 1'b1; nia_valid = 1'b1; nia_in = 32'h0000_3000;
    cyc(1); nia_in = 32'h0000_5000; #1;
    chk("hold_br_ready", {31'd0, br_ready}, 32'd0);
    chk("hold_addr", fetch_addr, 32'h0000_1000);
    cyc(1); br_valid = 1'b0; nia_valid = 1'b0; #1;
    chk("hold_addr2",  fetch_addr, 32'h0000_1000);
    chk("hold_epoch",  {30'd0, fetch_epoch}, 32'd1);
    fetch_ready = 1'b1;
    cyc(1); #1;
    chk("unhold_addr",  fetch_addr, 32'h0000_3000);
    chk("unhold_epoch", {30'd0, fetch_epoch}, 32'd2);
    chk("unhold_br_ready", {31'd0, br_ready}, 32'd1);

    // Branch without nia_valid: plain increment, epoch unchanged
    br_valid = 1'b1; nia_valid = 1'b0; nia_in = 32'hDEAD_BEEF;
    cyc(1); br_valid = 1'b0; #1;
    chk("nonredir_addr",  fetch_addr, 32'h0000_3004);
    chk("nonredir_epoch", {30'd0, fetch_epoch}, 32'd2);

    // Branch LR write collides with mtspr LR: branch wins
    fetch_ready = 1'b0;
    br_valid = 1'b1; link_reg_valid = 1'b1; link_reg_in = 32'hAAAA_0000;
    spr_valid = 1'b1; spr_sel = 1'b0; spr_data = 32'h5555_1111; #1;
    chk("lr_conflict_spr_ready", {31'd0, spr_ready}, 32'd0);
    cyc(1);
    // Branch LR write alongside mtspr CTR: both accepted
    link_reg_in = 32'hBBBB_0000; spr_sel = 1'b1; spr_data = 32'h1234_5678; #1;
    chk("lr_after_conflict", link_reg_out, 32'hAAAA_0000);
    chk("ctr_spr_ready", {31'd0, spr_ready}, 32'd1);
    cyc(1);
    br_valid = 1'b0; link_reg_valid = 1'b0; spr_valid = 1'b0; #1;
    chk("lr_second",  link_reg_out,  32'hBBBB_0000);
    chk("ctr_by_spr", count_reg_out, 32'h1234_5678);

    // Branch writes LR and CTR together; mtspr CTR is refused
    br_valid = 1'b1; link_reg_valid = 1'b1; count_reg_valid = 1'b1;
    link_reg_in = 32'h0000_1111; count_reg_in = 32'h0000_2222;
    spr_valid = 1'b1; spr_sel = 1'b1; spr_data = 32'hFFFF_0000; #1;
    chk("ctr_conflict_spr_ready", {31'd0, spr_ready}, 32'd0);
    cyc(1);
    br_valid = 1'b0; link_reg_valid = 1'b0; count_reg_valid = 1'b0;
    spr_sel = 1'b0; spr_data = 32'hCAFE_0004; #1;
    chk("both_lr",  link_reg_out,  32'h0000_1111);
    chk("both_ctr", count_reg_out, 32'h0000_2222);
    cyc(1); spr_valid = 1'b0; #1;
    chk("spr_lr",  link_reg_out,  32'hCAFE_0004);
    chk("spr_ctr", count_reg_out, 32'h0000_2222);
    chk("stall_addr", fetch_addr, 32'h0000_3004);

    // PC wrap at the top of the address space
    fetch_ready = 1'b1; br_valid = 1'b1; nia_valid = 1'b1; nia_in = 32'hFFFF_FFFF;
    cyc(1); br_valid = 1'b0; nia_valid = 1'b0; #1;
    chk("top_addr",  fetch_addr, 32'hFFFF_FFFC);
    chk("top_epoch", {30'd0, fetch_epoch}, 32'd3);
    cyc(1); #1;
    chk("wrap_addr", fetch_addr, 32'h0000_0000);

    // The epoch wraps from 3 to 0
    br_valid = 1'b1; nia_valid = 1'b1; nia_in = 32'h0000_0040;
    cyc(1); br_valid = 1'b0; nia_valid = 1'b0; #1;
    chk("epwrap_addr",  fetch_addr, 32'h0000_0040);
    chk("epwrap_epoch", {30'd0, fetch_epoch}, 32'd0);

    // Reset asserted in HOLD clears everything, including the pending redirect
    fetch_ready = 1'b0; br_valid = 1'b1; nia_valid = 1'b1; nia_in = 32'h0000_7000;
    cyc(1); br_valid = 1'b0; nia_valid = 1'b0; #1;
    chk("pre_rst_hold", {31'd0, br_ready}, 32'd0);
    rst = 1'b1;
    cyc(1); rst = 1'b0; #1;
    chk("rst_hold_addr",  fetch_addr, 32'h0000_0100);
    chk("rst_hold_epoch", {30'd0, fetch_epoch}, 32'd0);
    chk("rst_hold_lr",    link_reg_out,  32'd0);
    chk("rst_hold_ctr",   count_reg_out, 32'd0);
    chk("rst_hold_run",   {31'd0, br_ready}, 32'd1);
    fetch_ready = 1'b1;
    cyc(1); #1;
    chk("rst_hold_next", fetch_addr, 32'h0000_0104);
    chk("rst_hold_ep2",  {30'd0, fetch_epoch}, 32'd0);

    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
